// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// Optional macro IMULDIV_DIV_BYZERO_FASTPATH_EN: divide-by-zero skips CALC.
module imuldiv_int_div_iterative (
    input  logic        clk,
    input  logic        reset,
    input  logic        divreq_msg_fn,
    input  logic [31:0] divreq_msg_a,
    input  logic [31:0] divreq_msg_b,
    input  logic        divreq_val,
    output logic        divreq_rdy,
    output logic [63:0] divresp_msg_result,
    output logic        divresp_val,
    input  logic        divresp_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic [63:0] acc_q, acc_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fn_q, fn_d;
    logic        sgn_quo_q, sgn_quo_d;
    logic        sgn_rem_q, sgn_rem_d;
    logic        dbz_q, dbz_d;

    logic        req_fire;
    logic        resp_fire;
    logic        last_iter;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [64:0] acc_sh;
    logic [32:0] diff;
    logic [31:0] quo_raw;
    logic [31:0] rem_raw;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign req_fire  = divreq_val && divreq_rdy;
    assign resp_fire = divresp_val && divresp_rdy;
    assign last_iter = (cnt_q == 32'd31);

    assign a_mag = (divreq_msg_fn && divreq_msg_a[31]) ?
                   (~divreq_msg_a + 32'd1) : divreq_msg_a;
    assign b_mag = (divreq_msg_fn && divreq_msg_b[31]) ?
                   (~divreq_msg_b + 32'd1) : divreq_msg_b;

    // Restoring step: shift {rem, dividend} left, trial-subtract divisor.
    assign acc_sh = {acc_q, 1'b0};
    assign diff   = acc_sh[64:32] - {1'b0, dsr_q};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef IMULDIV_DIV_BYZERO_FASTPATH_EN
                if (last_iter || dbz_q) begin
                    state_d = DONE;
                end
`else
                if (last_iter) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (resp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state
    always_comb begin
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        dvd_d     = dvd_q;
        cnt_d     = cnt_q;
        fn_d      = fn_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        dbz_d     = dbz_q;
        if (req_fire) begin
            acc_d     = {32'd0, a_mag};
            dsr_d     = b_mag;
            dvd_d     = divreq_msg_a;
            cnt_d     = 32'd0;
            fn_d      = divreq_msg_fn;
            sgn_quo_d = divreq_msg_fn &
                        (divreq_msg_a[31] ^ divreq_msg_b[31]);
            sgn_rem_d = divreq_msg_fn & divreq_msg_a[31];
            dbz_d     = (divreq_msg_b == 32'd0);
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 32'd1;
            if (!diff[32]) begin
                acc_d = {diff[31:0], acc_sh[31:1], 1'b1};
            end else begin
                acc_d = acc_sh[63:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= 64'd0;
            dsr_q     <= 32'd0;
            dvd_q     <= 32'd0;
            cnt_q     <= 32'd0;
            fn_q      <= 1'b0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            dvd_q     <= dvd_d;
            cnt_q     <= cnt_d;
            fn_q      <= fn_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quo_raw = acc_q[31:0];
    assign rem_raw = acc_q[63:32];

    // Divide-by-zero overrides the sign fix-up in both modes.
    always_comb begin
        quo_fix = sgn_quo_q ? (~quo_raw + 32'd1) : quo_raw;
        rem_fix = sgn_rem_q ? (~rem_raw + 32'd1) : rem_raw;
        if (dbz_q) begin
            quo_fix = 32'hffff_ffff;
            rem_fix = dvd_q;
        end
        if (!fn_q && !dbz_q) begin
            quo_fix = quo_raw;
            rem_fix = rem_raw;
        end
    end

    // Output logic
    always_comb begin
        divreq_rdy         = 1'b0;
        divresp_val        = 1'b0;
        divresp_msg_result = 64'd0;
        unique case (state_q)
            IDLE: begin
                divreq_rdy = !reset;
            end
            CALC: begin
                divreq_rdy = 1'b0;
            end
            DONE: begin
                divresp_val = !reset;
                if (!reset) begin
                    divresp_msg_result = {rem_fix, quo_fix};
                end
            end
            default: begin
                divreq_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Directed self-checking bench for the iterative divider.
// Covers signed/unsigned vectors, edge cases, latency, backpressure, reset.
module tb_imuldiv_int_div_iterative;

    logic        clk;
    logic        reset;
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        req_val;
    logic        req_rdy;
    logic [63:0] result;
    logic        resp_val;
    logic        resp_rdy;

    int n_chk;
    int n_pass;

    logic [64:0] reqs [12];
    logic [63:0] exps [12];

    imuldiv_int_div_iterative dut (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (fn),
        .divreq_msg_a       (a),
        .divreq_msg_b       (b),
        .divreq_val         (req_val),
        .divreq_rdy         (req_rdy),
        .divresp_msg_result (result),
        .divresp_val        (resp_val),
        .divresp_rdy        (resp_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic f,
                          input logic [31:0] aa,
                          input logic [31:0] bb);
        int w;
        fn      = f;
        a       = aa;
        b       = bb;
        req_val = 1'b1;
        w       = 0;
        while (!req_rdy && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!req_rdy) check("req_rdy_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_val = 1'b0;
        a       = $urandom;
        b       = $urandom;
        fn      = 1'($urandom_range(0, 1));
    endtask

    task automatic get_resp(input string tag,
                            input logic [63:0] exp,
                            input int hold,
                            input int exp_lat);
        int cyc;
        cyc = 0;
        while (!resp_val && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_val"}, 64'(resp_val), 64'd1);
        if (exp_lat > 0) check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check(tag, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold"}, result, exp);
            check({tag, "_hold_rdy"}, 64'(req_rdy), 64'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        resp_rdy = 1'b0;
        check({tag, "_drop"}, 64'(resp_val), 64'd0);
    endtask

    initial begin
        int dbz_lat;
        logic saw;
`ifdef IMULDIV_DIV_BYZERO_FASTPATH_EN
        dbz_lat = 1;
`else
        dbz_lat = 32;
`endif
        n_chk    = 0;
        n_pass   = 0;
        reset    = 1'b1;
        fn       = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;

        reqs[0]  = {1'b1, 32'h00000222, 32'h0000002a};
        exps[0]  = 64'h00000000_0000000d;
        reqs[1]  = {1'b1, 32'hdeadbeef, 32'h0000beef};
        exps[1]  = 64'hffffda72_ffffd353;
        reqs[2]  = {1'b1, 32'h0a01b044, 32'hffffb14a};
        exps[2]  = 64'h00003372_ffffdf75;
        reqs[3]  = {1'b1, 32'hf5fe4fbc, 32'h00004eb6};
        exps[3]  = 64'hffffcc8e_ffffdf75;
        reqs[4]  = {1'b1, 32'hf5fe4fbc, 32'hffffb14a};
        exps[4]  = 64'hffffcc8e_0000208b;
        reqs[5]  = {1'b1, 32'hffffffff, 32'hffffffff};
        exps[5]  = 64'h00000000_00000001;
        reqs[6]  = {1'b0, 32'hdeadbeef, 32'h0000beef};
        exps[6]  = 64'h0000227f_00012a90;
        reqs[7]  = {1'b0, 32'hf5fe4fbc, 32'hffffb14a};
        exps[7]  = 64'hf5fe4fbc_00000000;
        reqs[8]  = {1'b0, 32'h00000032, 32'h00000222};
        exps[8]  = 64'h00000032_00000000;
        reqs[9]  = {1'b0, 32'h00000064, 32'h00000007};
        exps[9]  = 64'h00000002_0000000e;
        reqs[10] = {1'b1, 32'h00000007, 32'hfffffffe};
        exps[10] = 64'h00000001_fffffffd;
        reqs[11] = {1'b1, 32'hfffffff9, 32'h00000002};
        exps[11] = 64'hffffffff_fffffffd;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(req_rdy), 64'd0);
        check("rst_val", 64'(resp_val), 64'd0);
        check("rst_res", result, 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_rdy", 64'(req_rdy), 64'd1);

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_req(reqs[i][64], reqs[i][63:32], reqs[i][31:0]);
            get_resp($sformatf("vec%0d", i), exps[i],
                     $urandom_range(0, 3), 32);
        end

        do_req(1'b0, 32'h00000005, 32'h00000000);
        get_resp("dbz_u", 64'h00000005_ffffffff, 0, dbz_lat);
        do_req(1'b1, 32'hfffffffb, 32'h00000000);
        get_resp("dbz_s", 64'hfffffffb_ffffffff, 0, dbz_lat);
        do_req(1'b1, 32'h80000000, 32'hffffffff);
        get_resp("ovf", 64'h00000000_80000000, 10, 32);

        do_req(1'b1, 32'd100, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rdy", 64'(req_rdy), 64'd0);
        check("mid_rst_val", 64'(resp_val), 64'd0);
        check("mid_rst_res", result, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_rdy1", 64'(req_rdy), 64'd1);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_val) saw = 1'b1;
        end
        check("rst_noresp", 64'(saw), 64'd0);
        do_req(1'b1, 32'h00000001, 32'h00000001);
        get_resp("after_rst", 64'h00000000_00000001, 0, 32);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
